keccak_absorb_loader: RTL and testbench

KECCAK_ABSORB_LOADER -- requirements
Module: keccak_absorb_loader

---
 rtl/keccak_absorb_loader.sv | 226 ++++++++++++++++++++++
 tb/tb_keccak_absorb_loader.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/keccak_absorb_loader.sv
// Keccak absorb front end: parses a 64-bit header, packs message words into a
// rate-sized block, applies the pad10*1 domain padding and hands blocks downstream.
module keccak_absorb_loader #(
  parameter int W        = 64,
  parameter int RATE_MAX = 1344
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        in_data,
  output logic                blk_valid,
  input  logic                blk_ready,
  output logic [RATE_MAX-1:0] blk_data,
  output logic                blk_last,
  output logic [1:0]          blk_mode,
  output logic [31:0]         out_size,
  output logic                busy
);

  localparam int BPW    = W / 8;
  localparam int NBYTES = RATE_MAX / 8;
  localparam int KW     = $clog2(RATE_MAX / W + 1);
  localparam int NBW    = $clog2(NBYTES + 1);

  typedef enum logic [1:0] {HEADER, ABSORB, PAD, EMIT} state_t;

  state_t          r_state;
  logic            r_in_ready;
  logic            r_blk_valid;
  logic            r_blk_last;
  logic            r_busy;
  logic [1:0]      r_mode;
  logic [31:0]     r_out_size;
  logic [31:0]     r_rem;
  logic [KW-1:0]   r_k;
  logic [NBW-1:0]  r_nbytes;
  logic            r_ended;

  logic            w_in_xfer;
  logic            w_blk_xfer;
  logic            w_hdr_xfer;
  logic            w_hdr_done;
  logic [1:0]      w_hdr_mode;
  logic [27:0]     w_hdr_size;
  logic [31:0]     w_hdr_len;
  logic [31:0]     w_nb;
  logic            w_msg_end;
  logic            w_fill;
  logic [NBW-1:0]  w_rate_bytes;
  logic [7:0]      w_suffix;
  logic [W-1:0]    w_masked;
  logic            w_clear;
  logic            w_wr_en;
  logic            w_pad_en;

  assign w_in_xfer  = in_valid & r_in_ready;
  assign w_blk_xfer = blk_ready & r_blk_valid;
  assign w_hdr_xfer = (r_state == HEADER) & w_in_xfer;

  // Header assembly: one word at W=64, low word then high word at W=32.
  generate
    if (W == 32) begin : g_hdr32
      logic        r_hdr_phase;
      logic [31:0] r_hdr_lo;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_hdr_phase <= 1'b0;
          r_hdr_lo    <= '0;
        end else if (w_hdr_xfer) begin
          r_hdr_phase <= ~r_hdr_phase;
          if (!r_hdr_phase) r_hdr_lo <= in_data[31:0];
        end
      end
      assign w_hdr_done = r_hdr_phase;
      assign w_hdr_mode = in_data[30:29];
      assign w_hdr_size = in_data[27:0];
      assign w_hdr_len  = r_hdr_lo;
    end else begin : g_hdr64
      assign w_hdr_done = 1'b1;
      assign w_hdr_mode = in_data[62:61];
      assign w_hdr_size = in_data[59:32];
      assign w_hdr_len  = in_data[31:0];
    end
  endgenerate

  always_comb begin
    w_rate_bytes = NBW'(168);
    w_suffix     = 8'h1F;
    case (r_mode)
      2'b01:   begin w_rate_bytes = NBW'(136); w_suffix = 8'h1F; end
      2'b10:   begin w_rate_bytes = NBW'(136); w_suffix = 8'h06; end
      2'b11:   begin w_rate_bytes = NBW'(72);  w_suffix = 8'h06; end
      default: begin w_rate_bytes = NBW'(168); w_suffix = 8'h1F; end
    endcase
  end

  assign w_nb      = (r_rem < 32'(BPW)) ? r_rem : 32'(BPW);
  assign w_msg_end = (r_rem == w_nb);
  // Fill is judged in bytes so a short final word never counts as a full block.
  assign w_fill    = ((r_nbytes + NBW'(w_nb)) == w_rate_bytes);

  genvar gi;
  generate
    for (gi = 0; gi < BPW; gi++) begin : g_mask
      assign w_masked[gi*8 +: 8] = (32'(gi) < w_nb) ? in_data[gi*8 +: 8] : 8'h00;
    end
  endgenerate

  assign w_clear  = (w_hdr_xfer & w_hdr_done) | ((r_state == EMIT) & w_blk_xfer);
  assign w_wr_en  = (r_state == ABSORB) & w_in_xfer;
  assign w_pad_en = (r_state == PAD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= HEADER;
      r_in_ready  <= 1'b1;
      r_blk_valid <= 1'b0;
      r_blk_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_mode      <= '0;
      r_out_size  <= '0;
      r_rem       <= '0;
      r_k         <= '0;
      r_nbytes    <= '0;
      r_ended     <= 1'b0;
    end else begin
      case (r_state)
        HEADER: begin
          if (w_in_xfer && w_hdr_done) begin
            r_mode     <= w_hdr_mode;
            r_out_size <= {4'b0, w_hdr_size};
            r_rem      <= w_hdr_len;
            r_k        <= '0;
            r_nbytes   <= '0;
            r_ended    <= 1'b0;
            r_busy     <= 1'b1;
            if (w_hdr_len != 32'd0) begin
              r_state <= ABSORB;
            end else begin
              r_state    <= PAD;
              r_in_ready <= 1'b0;
            end
          end
        end
        ABSORB: begin
          if (w_in_xfer) begin
            r_k      <= r_k + KW'(1);
            r_rem    <= r_rem - w_nb;
            r_nbytes <= r_nbytes + NBW'(w_nb);
            if (w_fill) begin
              r_state     <= EMIT;
              r_in_ready  <= 1'b0;
              r_blk_valid <= 1'b1;
              r_blk_last  <= 1'b0;
              r_ended     <= w_msg_end;
            end else if (w_msg_end) begin
              r_state    <= PAD;
              r_in_ready <= 1'b0;
            end
          end
        end
        PAD: begin
          r_state     <= EMIT;
          r_blk_valid <= 1'b1;
          r_blk_last  <= 1'b1;
        end
        EMIT: begin
          if (w_blk_xfer) begin
            r_blk_valid <= 1'b0;
            r_blk_last  <= 1'b0;
            r_k         <= '0;
            r_nbytes    <= '0;
            if (r_blk_last) begin
              r_state    <= HEADER;
              r_in_ready <= 1'b1;
              r_busy     <= 1'b0;
            end else if (r_ended) begin
              // Message ended on a block boundary: an all-padding block follows.
              r_state    <= PAD;
              r_in_ready <= 1'b0;
              r_ended    <= 1'b0;
            end else begin
              r_state    <= ABSORB;
              r_in_ready <= 1'b1;
            end
          end
        end
        default: begin
          r_state    <= HEADER;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  // Each buffer byte is its own register: word write, padding update or clear.
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_byte
      localparam int WI = gi / BPW;
      localparam int BI = gi % BPW;
      logic [7:0] r_byte;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_byte <= 8'h00;
        end else if (w_clear) begin
          r_byte <= 8'h00;
        end else if (w_wr_en && (r_k == KW'(WI))) begin
          r_byte <= w_masked[BI*8 +: 8];
        end else if (w_pad_en) begin
          r_byte <= (r_byte ^ ((r_nbytes == NBW'(gi)) ? w_suffix : 8'h00))
                  | ((w_rate_bytes == NBW'(gi + 1)) ? 8'h80 : 8'h00);
        end
      end
      assign blk_data[gi*8 +: 8] = r_byte;
    end
  endgenerate

  assign in_ready  = r_in_ready;
  assign blk_valid = r_blk_valid;
  assign blk_last  = r_blk_last;
  assign blk_mode  = r_mode;
  assign out_size  = r_out_size;
  assign busy      = r_busy;

endmodule

// File: tb/tb_keccak_absorb_loader.sv
// Directed bench for keccak_absorb_loader at W=64: header parsing, packing,
// padding per mode, emit back-pressure and mid-message reset.
module tb_keccak_absorb_loader;

  localparam int W = 64;
  localparam int RM = 1344;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          blk_valid;
  logic          blk_ready;
  logic [RM-1:0] blk_data;
  logic          blk_last;
  logic [1:0]    blk_mode;
  logic [31:0]   out_size;
  logic          busy;

  int checks = 0;
  int errors = 0;
  logic [RM-1:0] last_blk;

  keccak_absorb_loader #(.W(W), .RATE_MAX(RM)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_last(blk_last), .blk_mode(blk_mode), .out_size(out_size), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_blk(input string tag, input logic [RM-1:0] obs, input logic [RM-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] hdr(input logic [1:0] m, input logic [27:0] sz, input logic [31:0] len);
    return {1'b0, m, 1'b0, sz, len};
  endfunction

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37 + 11) % 256);
  endfunction

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send(input logic [63:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic get_block(input string tag, input logic [RM-1:0] exp, input logic exp_last,
                           input logic [1:0] exp_mode, input logic [31:0] exp_size,
                           input bit stall, input bit immediate);
    int n = 0;
    if (immediate) begin
      chk({tag, "_latency"}, blk_valid, 1'b1);
    end else begin
      while (!blk_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk({tag, "_valid"}, blk_valid, 1'b1);
    end
    last_blk = blk_data;
    chk_blk({tag, "_data"}, blk_data, exp);
    chk({tag, "_last"}, blk_last, exp_last);
    chk({tag, "_mode"}, blk_mode, exp_mode);
    chk({tag, "_size"}, out_size, exp_size);
    if (stall) begin
      for (int c = 0; c < 5; c++) begin
        in_valid = (c % 2 == 0);
        in_data  = {$urandom, $urandom};
        @(negedge clk);
        chk_blk({tag, "_stall_data"}, blk_data, exp);
        chk({tag, "_stall_ready"}, in_ready, 1'b0);
        chk({tag, "_stall_valid"}, blk_valid, 1'b1);
      end
      in_valid = 1'b0;
    end
    blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;
    chk({tag, "_done"}, blk_valid, 1'b0);
  endtask

  // Patterned message; bytes past L in the last word are 0xEE and must be dropped.
  task automatic run_msg(input string tag, input logic [1:0] m, input int len,
                         input logic [27:0] sz, input bit stall_first);
    int rate;
    logic [7:0] sfx;
    int nwords;
    int blk_n = 0;
    int p;
    int start;
    logic [63:0] w;
    logic [RM-1:0] e;
    case (m)
      2'b00:   begin rate = 168; sfx = 8'h1F; end
      2'b01:   begin rate = 136; sfx = 8'h1F; end
      2'b10:   begin rate = 136; sfx = 8'h06; end
      default: begin rate = 72;  sfx = 8'h06; end
    endcase
    send(hdr(m, sz, 32'(len)));
    nwords = (len + 7) / 8;
    for (int wi = 0; wi < nwords; wi++) begin
      for (int b = 0; b < 8; b++)
        w[b*8 +: 8] = (wi*8 + b < len) ? pat(wi*8 + b) : 8'hEE;
      send(w);
      if ((wi+1)*8 <= len && ((wi+1)*8) % rate == 0) begin
        e = '0;
        for (int i = 0; i < rate; i++) e[i*8 +: 8] = pat(blk_n*rate + i);
        get_block({tag, "_full"}, e, 1'b0, m, {4'b0, sz}, stall_first && blk_n == 0, 1'b1);
        blk_n++;
      end
    end
    p = len % rate;
    start = (len / rate) * rate;
    e = '0;
    for (int i = 0; i < p; i++) e[i*8 +: 8] = pat(start + i);
    e[p*8 +: 8] = e[p*8 +: 8] ^ sfx;
    e[(rate-1)*8 +: 8] = e[(rate-1)*8 +: 8] | 8'h80;
    get_block({tag, "_final"}, e, 1'b1, m, {4'b0, sz}, 1'b0, 1'b0);
  endtask

  logic [RM-1:0] e38;
  logic [RM-1:0] e39;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; blk_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_blk_valid", blk_valid, 1'b0);
    chk("rst_blk_last", blk_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk_blk("rst_blk_data", blk_data, '0);
    chk("rst_blk_mode", blk_mode, 2'b00);
    chk("rst_out_size", out_size, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // SHAKE128, empty message
    e38 = '0;
    e38[7:0] = 8'h1F;
    e38[167*8 +: 8] = 8'h80;
    send(hdr(2'b00, 28'd32, 32'd0));
    chk("l0_busy", busy, 1'b1);
    get_block("l0", e38, 1'b1, 2'b00, 32'd32, 1'b0, 1'b0);
    chk("l0_idle_busy", busy, 1'b0);
    chk("l0_idle_ready", in_ready, 1'b1);

    // SHA3-256, 3 bytes with garbage in upper bytes of the word
    e39 = '0;
    e39[31:0] = 32'h06CCBBAA;
    e39[135*8 +: 8] = 8'h80;
    send(hdr(2'b10, 28'd256, 32'd3));
    send(64'hDEADBEEF11CCBBAA);
    get_block("l3", e39, 1'b1, 2'b10, 32'd256, 1'b0, 1'b0);

    // SHAKE256, exactly one rate of data, with emit back-pressure on block 1
    run_msg("l136", 2'b01, 136, 28'd512, 1'b1);
    chk("l136_pad_b0", last_blk[7:0], 8'h1F);
    chk("l136_pad_b135", last_blk[135*8 +: 8], 8'h80);

    // SHA3-512, 71 bytes: combined padding byte at the end of the rate
    run_msg("l71", 2'b11, 71, 28'd64, 1'b0);
    chk("l71_b71", last_blk[71*8 +: 8], 8'h86);
    chk_blk("l71_upper_zero", last_blk >> 576, '0);

    // Two-block SHA3-256 message with a partial second block
    run_msg("l150", 2'b10, 150, 28'd32, 1'b0);

    // Reset mid-message, then an empty SHAKE128 message
    send(hdr(2'b01, 28'd100, 32'd136));
    for (int i = 0; i < 4; i++) send({32'hCAFE0000, 32'(i)});
    rst = 1'b1;
    #1;
    chk("mrst_blk_valid", blk_valid, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_in_ready", in_ready, 1'b1);
    chk_blk("mrst_blk_data", blk_data, '0);
    chk("mrst_out_size", out_size, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_no_block", blk_valid, 1'b0);
    send(hdr(2'b00, 28'd32, 32'd0));
    get_block("mrst_l0", e38, 1'b1, 2'b00, 32'd32, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
